// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM download loader: FSM state and FIFO entry.
package rom_loader_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    // Word-address field is sized for the widest supported ioctl address.
    localparam int unsigned WADDR_MAX = 32;

    typedef struct packed {
        logic [WADDR_MAX-1:0] waddr;
        logic [15:0]          data;
    } fifo_entry_t;

endpackage

// File: rtl/rom_loader_fifo.sv
// Synchronous FIFO of packed words; a push on a full FIFO is accepted only with a same-cycle pop.
module rom_loader_fifo
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t dout,
    output logic        full,
    output logic        empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    fifo_entry_t mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Packs ioctl download bytes into big-endian words and streams them to SDRAM.
// Define ROM_LOADER_CHECKSUM_EN to enable the 16-bit download byte checksum.
module rom_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 25
) (
    input  logic          clk_96M,
    input  logic          reset,
    input  logic          rom_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-2:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic          rom_loaded,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   checksum
);
    import rom_loader_pkg::*;

    state_t      state;
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic        wr_ok;
    logic [AW-2:0] waddr;

    logic        pend_valid;
    logic [7:0]  pend_byte;
    logic [AW-2:0] pend_waddr;
    logic        push_q;
    fifo_entry_t push_entry;

    logic        flush_push;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    fifo_entry_t fifo_din;
    fifo_entry_t fifo_head;
    logic        unused_head_hi;

    assign waddr          = ioctl_addr[AW-1:1];
    assign dl_rise        = rom_download & ~dl_q;
    assign dl_fall        = ~rom_download & dl_q;
    assign wr_ok          = ioctl_wr & rom_download;
    assign flush_push     = (state == FLUSH) & pend_valid;
    assign fifo_push      = push_q | flush_push;
    assign fifo_pop       = sdram_req & sdram_ack;
    assign busy           = (state == LOAD) || (state == FLUSH) || (state == DRAIN);
    assign unused_head_hi = ^fifo_head.waddr[WADDR_MAX-1:AW-1];

    // Writes are ignored while rom_download is low, so push_q never collides with the flush push.
    always_comb begin
        fifo_din = push_entry;
        if (!push_q) begin
            fifo_din.waddr = WADDR_MAX'(pend_waddr);
            fifo_din.data  = {pend_byte, 8'hFF};
        end
    end

    always_ff @(posedge clk_96M) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            pend_waddr <= '0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            push_q <= 1'b0;
            if (state == FLUSH) pend_valid <= 1'b0;
            if (wr_ok) begin
                if (!ioctl_addr[0]) begin
                    // A second even byte evicts the unpaired one as a half word.
                    if (pend_valid) begin
                        push_q           <= 1'b1;
                        push_entry.waddr <= WADDR_MAX'(pend_waddr);
                        push_entry.data  <= {pend_byte, 8'hFF};
                    end
                    pend_valid <= 1'b1;
                    pend_byte  <= ioctl_dout;
                    pend_waddr <= waddr;
                end else begin
                    push_q           <= 1'b1;
                    push_entry.waddr <= WADDR_MAX'(waddr);
                    if (pend_valid && (pend_waddr == waddr)) begin
                        push_entry.data <= {pend_byte, ioctl_dout};
                        pend_valid      <= 1'b0;
                    end else begin
                        push_entry.data <= {8'hFF, ioctl_dout};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_96M) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_din  <= '0;
        end else begin
            dl_q <= rom_download;
            if (dl_rise) begin
                rom_loaded <= 1'b0;
                overflow   <= 1'b0;
            end
            if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;

            case (state)
                IDLE, DONE: if (dl_rise) state <= LOAD;
                LOAD:       if (dl_fall) state <= FLUSH;
                FLUSH:      state <= dl_rise ? LOAD : DRAIN;
                DRAIN: begin
                    if (dl_rise) begin
                        state <= LOAD;
                    end else if (fifo_empty && !sdram_req) begin
                        state      <= DONE;
                        rom_loaded <= 1'b1;
                    end
                end
                default:    state <= IDLE;
            endcase

            // Dropping req on the ack cycle forces a one-cycle gap before the next request.
            if (fifo_pop) begin
                sdram_req <= 1'b0;
            end else if (!sdram_req && !fifo_empty) begin
                sdram_req  <= 1'b1;
                sdram_addr <= fifo_head.waddr[AW-2:0];
                sdram_din  <= fifo_head.data;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk_96M) begin
        if (reset) begin
            sum <= '0;
        end else if (dl_rise) begin
            sum <= wr_ok ? {8'h00, ioctl_dout} : '0;
        end else if (wr_ok) begin
            sum <= sum + {8'h00, ioctl_dout};
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

    rom_loader_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_96M),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed scenarios plus randomized downloads against an address-map word model.
module tb_rom_loader;
    localparam int unsigned AW    = 25;
    localparam int unsigned DEPTH = 4;

    logic          clk_96M = 1'b0;
    logic          reset;
    logic          rom_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          sdram_req;
    logic          sdram_ack;
    logic [AW-2:0] sdram_addr;
    logic [15:0]   sdram_din;
    logic          rom_loaded;
    logic          busy;
    logic          overflow;
    logic [15:0]   checksum;

    always #5 clk_96M = ~clk_96M;

    rom_loader #(
        .FIFO_DEPTH(DEPTH),
        .AW(AW)
    ) dut (
        .clk_96M      (clk_96M),
        .reset        (reset),
        .rom_download (rom_download),
        .ioctl_wr     (ioctl_wr),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .sdram_req    (sdram_req),
        .sdram_ack    (sdram_ack),
        .sdram_addr   (sdram_addr),
        .sdram_din    (sdram_din),
        .rom_loaded   (rom_loaded),
        .busy         (busy),
        .overflow     (overflow),
        .checksum     (checksum)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    word_t       exp_q[$];
    logic [7:0]  dl_bytes[$];
    logic [15:0] ck_exp;
    int unsigned commits;

    // SDRAM responder state
    logic        ack_en;
    int unsigned lat_min, lat_max, wait_cnt;
    logic        in_req, popped, stale_ack;
    logic [31:0] cap_addr, cap_din;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic commit();
        word_t w;
        commits++;
        if (exp_q.size() == 0) begin
            check("commit_extra", 32'(exp_q.size()), 32'd1);
        end else begin
            w = exp_q.pop_front();
            check("commit_addr", 32'(sdram_addr), w.addr);
            check("commit_din", 32'(sdram_din), w.data);
        end
    endtask

    // One clock: passes a rising edge, then plays the SDRAM side at the falling edge.
    task automatic tick();
        @(negedge clk_96M);
        if (popped) check("req_gap", 32'(sdram_req), 32'd0);
        popped    = 1'b0;
        sdram_ack = 1'b0;
        if (reset) begin
            in_req = 1'b0;
        end else if (sdram_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                cap_addr = 32'(sdram_addr);
                cap_din  = 32'(sdram_din);
                wait_cnt = $urandom_range(lat_max, lat_min);
            end else begin
                check("addr_stable", 32'(sdram_addr), cap_addr);
                check("din_stable", 32'(sdram_din), cap_din);
            end
            if (ack_en) begin
                if (wait_cnt == 0) begin
                    sdram_ack = 1'b1;
                    popped    = 1'b1;
                    in_req    = 1'b0;
                    commit();
                end else begin
                    wait_cnt--;
                end
            end
        end else if (stale_ack) begin
            sdram_ack = 1'b1;
            stale_ack = 1'b0;
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic start_dl();
        rom_download = 1'b1;
        ck_exp       = '0;
        tick();
    endtask

    task automatic end_dl();
        rom_download = 1'b0;
        tick();
    endtask

    task automatic write_byte(input int unsigned addr, input logic [7:0] data);
        ioctl_wr   = 1'b1;
        ioctl_addr = AW'(addr);
        ioctl_dout = data;
        ck_exp     = ck_exp + 16'(data);
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send(input int unsigned base, input int unsigned gmin, input int unsigned gmax);
        start_dl();
        foreach (dl_bytes[i]) begin
            write_byte(base + i, dl_bytes[i]);
            cycles($urandom_range(gmax, gmin));
        end
        end_dl();
    endtask

    // Word view of a contiguous byte run: missing half of an edge word reads as FF.
    task automatic expect_words(input int unsigned base, input int unsigned limit);
        int unsigned last, cnt;
        logic [7:0]  hi, lo;
        word_t       w;
        last = base + dl_bytes.size() - 1;
        cnt  = 0;
        for (int unsigned wa = base / 2; wa <= last / 2; wa++) begin
            hi = 8'hFF;
            lo = 8'hFF;
            if (2 * wa >= base) hi = dl_bytes[2 * wa - base];
            if (2 * wa + 1 <= last) lo = dl_bytes[2 * wa + 1 - base];
            w.addr = wa;
            w.data = {16'h0, hi, lo};
            if (cnt < limit) exp_q.push_back(w);
            cnt++;
        end
    endtask

    task automatic finish_dl(input string tag, input logic exp_ovf);
        int unsigned n = 0;
        while (!rom_loaded && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_loaded"}, 32'(rom_loaded), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
`ifdef ROM_LOADER_CHECKSUM_EN
        check({tag, "_sum"}, 32'(checksum), 32'(ck_exp));
`else
        check({tag, "_sum"}, 32'(checksum), 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        rom_download = 1'b0;
        ioctl_wr     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int unsigned c0, n, base;
        reset      = 1'b1;
        ioctl_addr = '0;
        ioctl_dout = '0;
        sdram_ack  = 1'b0;
        ack_en     = 1'b1;
        lat_min    = 0;
        lat_max    = 0;
        wait_cnt   = 0;
        in_req     = 1'b0;
        popped     = 1'b0;
        stale_ack  = 1'b0;
        commits    = 0;
        ck_exp     = '0;
        do_reset();

        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_loaded", 32'(rom_loaded), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_sum", 32'(checksum), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_din", 32'(sdram_din), 32'd0);

        // Single word, ack one cycle after request
        lat_min  = 1;
        lat_max  = 1;
        c0       = commits;
        dl_bytes = '{8'h12, 8'h34};
        expect_words(0, 1000);
        send(0, 0, 0);
        finish_dl("one_word", 1'b0);
        check("one_word_n", commits - c0, 32'd1);

        // Odd length: trailing even byte flushed as xxFF
        lat_min  = 0;
        lat_max  = 2;
        c0       = commits;
        dl_bytes = '{8'hAA, 8'hBB, 8'hCC};
        expect_words(0, 1000);
        send(0, 0, 1);
        finish_dl("odd_len", 1'b0);
        check("odd_len_n", commits - c0, 32'd2);

        // Checksum wrap
        dl_bytes = '{8'hFF, 8'hFF, 8'h02};
        expect_words(0, 1000);
        send(0, 0, 0);
        finish_dl("cksum", 1'b0);
`ifdef ROM_LOADER_CHECKSUM_EN
        check("cksum_val", 32'(checksum), 32'h0200);
`else
        check("cksum_val", 32'(checksum), 32'h0000);
`endif

        // Overflow: 6 words with acks held off
        ack_en = 1'b0;
        lat_min = 0;
        lat_max = 0;
        c0 = commits;
        dl_bytes.delete();
        repeat (12) dl_bytes.push_back(8'($urandom));
        expect_words(32'h100, DEPTH);
        send(32'h100, 0, 0);
        cycles(4);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_no_commit", commits - c0, 32'd0);
        ack_en = 1'b1;
        finish_dl("ovf", 1'b1);
        check("ovf_n", commits - c0, DEPTH);

        // Push and pop in the same cycle on a full FIFO
        ack_en = 1'b0;
        c0 = commits;
        dl_bytes.delete();
        repeat (10) dl_bytes.push_back(8'($urandom));
        expect_words(32'h200, 1000);
        start_dl();
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int unsigned i = 0; i < 9; i++) write_byte(32'h200 + i, dl_bytes[i]);
        cycles(2);
        ack_en = 1'b1;
        write_byte(32'h209, dl_bytes[9]);
        end_dl();
        finish_dl("full_pp", 1'b0);
        check("full_pp_n", commits - c0, 32'd5);

        // Reset while a request is outstanding
        ack_en = 1'b0;
        dl_bytes = '{8'h77, 8'h88};
        expect_words(32'h1A2, 1000);
        start_dl();
        write_byte(32'h1A2, 8'h77);
        write_byte(32'h1A3, 8'h88);
        n = 0;
        while (!sdram_req && n < 10) begin
            tick();
            n++;
        end
        check("pre_rst_req", 32'(sdram_req), 32'd1);
        reset        = 1'b1;
        rom_download = 1'b0;
        tick();
        check("mid_rst_req", 32'(sdram_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(sdram_addr), 32'd0);
        check("mid_rst_din", 32'(sdram_din), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        stale_ack = 1'b1;
        cycles(2);

        // Stray ack in the inter-request gap must not pop
        c0 = commits;
        dl_bytes.delete();
        repeat (6) dl_bytes.push_back(8'($urandom));
        expect_words(32'h40, 1000);
        start_dl();
        foreach (dl_bytes[i]) write_byte(32'h40 + i, dl_bytes[i]);
        cycles(2);
        stale_ack = 1'b1;
        ack_en    = 1'b1;
        end_dl();
        finish_dl("stray", 1'b0);
        check("stray_n", commits - c0, 32'd3);

        // New download starting while old words still drain
        ack_en = 1'b0;
        c0 = commits;
        dl_bytes.delete();
        repeat (4) dl_bytes.push_back(8'($urandom));
        expect_words(32'h300, 1000);
        send(32'h300, 0, 0);
        cycles(3);
        check("drain_busy", 32'(busy), 32'd1);
        dl_bytes.delete();
        repeat (2) dl_bytes.push_back(8'($urandom));
        expect_words(32'h310, 1000);
        send(32'h310, 0, 0);
        ack_en = 1'b1;
        finish_dl("redl", 1'b0);
        check("redl_n", commits - c0, 32'd3);

        // Randomized downloads
        lat_min = 0;
        lat_max = 2;
        for (int t = 0; t < 8; t++) begin
            base = $urandom_range(32'h3FF, 0);
            n    = $urandom_range(9, 1);
            dl_bytes.delete();
            repeat (n) dl_bytes.push_back(8'($urandom));
            expect_words(base, 1000);
            send(base, 1, 3);
            finish_dl("rand", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of packed-word entries (power of two, 2..16).
- REQ-002 SHALL have parameter AW, default 25, giving the ioctl byte-address width.
- REQ-003 SHALL have port clk_96M, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port rom_download, input, 1 bit: ROM download window (index 0) is active.
- REQ-006 SHALL have port ioctl_wr, input, 1 bit: one-cycle strobe marking a valid download byte.
- REQ-007 SHALL have port ioctl_addr, input, AW bits: byte address of the download byte.
- REQ-008 SHALL have port ioctl_dout, input, 8 bits: download byte.
- REQ-009 SHALL have port sdram_req, output, 1 bit: write request to the SDRAM controller.
- REQ-010 SHALL have port sdram_ack, input, 1 bit: one-cycle acceptance of the current request.
- REQ-011 SHALL have port sdram_addr, output, AW-1 bits: word address (byte address >> 1).
- REQ-012 SHALL have port sdram_din, output, 16 bits: packed write word.
- REQ-013 SHALL have port rom_loaded, output, 1 bit: every word of the last download is committed.
- REQ-014 SHALL have port busy, output, 1 bit: a download is in progress or FIFO data remains.
- REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, a word was dropped.
- REQ-016 SHALL have port checksum, output, 16 bits: see Configuration.

Function
- REQ-017 SHALL pack bytes big-endian (68000 order): even-address byte into [15:8], odd-address byte into [7:0].
- REQ-018 SHALL push a word into the FIFO on the cycle after its odd byte is written; word address = ioctl_addr[AW-1:1].
- REQ-019 SHALL treat an odd byte with no preceding even byte for that word (non-contiguous address) as a word with [15:8]=8'hFF.
- REQ-020 SHALL implement states IDLE, LOAD, FLUSH, DRAIN and DONE.
- REQ-021 SHALL transition IDLE/DONE->LOAD on the rom_download rising edge; LOAD->FLUSH on its falling edge; FLUSH->DRAIN after one cycle; DRAIN->DONE when the FIFO is empty and no request is outstanding.
- REQ-022 In FLUSH, SHALL push a pending even byte as a word with [7:0]=8'hFF; with no pending byte, FLUSH SHALL push nothing.
- REQ-023 SHALL hold sdram_req high with sdram_addr and sdram_din stable from assertion until the cycle sdram_ack is seen; the FIFO pops on that cycle.
- REQ-024 SHALL re-assert sdram_req no earlier than the cycle after an ack (at most one word per 2 cycles).
- REQ-025 SHALL ignore sdram_ack while sdram_req is low.
- REQ-026 SHALL accept a push and a pop in the same cycle when full (occupancy unchanged, no overflow).
- REQ-027 SHALL drop the word and set overflow when a push hits a full FIFO without a simultaneous pop; overflow clears only on reset or the next rom_download rising edge.
- REQ-028 SHALL set rom_loaded on entry to DONE and clear it on the rom_download rising edge; busy = state in {LOAD, FLUSH, DRAIN}.
- REQ-029 SHALL ignore ioctl_wr while rom_download is low.
- REQ-030 On a rom_download rising edge during DRAIN, SHALL finish draining the old words before committing new ones (FIFO not cleared).

Reset
- REQ-031 Reset SHALL set state=IDLE and sdram_req=0, rom_loaded=0, busy=0, overflow=0, checksum=0, sdram_addr=0, sdram_din=0.
- REQ-032 Reset SHALL empty the FIFO and discard the pending byte, including mid-request; an outstanding request SHALL be abandoned and a later stray ack ignored.

Configuration
- REQ-033 With ROM_LOADER_CHECKSUM_EN defined, checksum SHALL be the 16-bit wrap-around sum of all accepted download bytes, cleared on the rom_download rising edge.
- REQ-034 Without ROM_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesized.

Structure
- REQ-035 Package rom_loader_pkg SHALL hold the state enum and the FIFO entry struct (word address, data).
- REQ-036 The FIFO SHALL be sub-module rom_loader_fifo (synchronous, full/empty flags, simultaneous push/pop).

Verification
- REQ-037 Bytes 0x12@0, 0x34@1, ack 1 cycle after req -> one request, addr 0, din 0x1234; rom_loaded=1 after rom_download falls.
- REQ-038 Odd-length download, 3 bytes AA,BB,CC @0..2 -> words 0xAABB@0 and 0xCCFF@1.
- REQ-039 ack held low, 6 words written, FIFO_DEPTH=4 -> overflow=1, exactly 4 words committed once acks resume.
- REQ-040 Reset asserted while sdram_req=1 -> next cycle sdram_req=0, busy=0; stale ack then produces no pop.
- REQ-041 ROM_LOADER_CHECKSUM_EN build, bytes FF,FF,02 -> checksum 0x0200; build without the macro -> checksum 0.
- REQ-042 Push and pop in the same cycle on a full FIFO -> no overflow, word order preserved.
